// File: rtl/not_gate_checker.sv
// rtl/not_gate_checker.sv - drives a fixed 0,1,1,0 vector sequence into an inverter and counts wrong responses
module not_gate_checker #(
  parameter int NUM_VECTORS = 16,
  parameter int SETTLE      = 1,
  parameter int CNT_W       = 8,
  localparam int IDX_W      = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;

  state_t           state, state_nx;
  logic             a_nx;
  logic             pass_nx;
  logic [CNT_W-1:0] err_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [3:0]       wait_cnt, wait_nx;
  logic             idx_bit1;
  logic             mismatch;

  if (IDX_W > 1) begin : g_bit1
    assign idx_bit1 = vec_idx[1];
  end else begin : g_bit1_none
    assign idx_bit1 = 1'b0;
  end

  assign mismatch = (y_in != ~a_out);
  assign busy     = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_out     <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_idx   <= '0;
      wait_cnt  <= 4'd0;
    end else begin
      state     <= state_nx;
      a_out     <= a_nx;
      pass      <= pass_nx;
      err_count <= err_nx;
      vec_idx   <= idx_nx;
      wait_cnt  <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_out;
    pass_nx  = pass;
    err_nx   = err_count;
    idx_nx   = vec_idx;
    wait_nx  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          err_nx   = '0;
          idx_nx   = '0;
          pass_nx  = 1'b0;
          a_nx     = 1'b0;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (SETTLE > 0) begin
          wait_nx  = WAIT_LOAD;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_CHECK;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nx = S_CHECK;
        else                  wait_nx  = wait_cnt - 4'd1;
      end
      S_CHECK: begin
        if (mismatch && (err_count != ERR_MAX)) err_nx = err_count + 1'b1;
        if (vec_idx == LAST_IDX) begin
          pass_nx  = (err_nx == '0);
          a_nx     = 1'b0;
          state_nx = S_DONE;
        end else begin
          idx_nx   = vec_idx + 1'b1;
          // (k+1)[1] ^ (k+1)[0] reduces to ~k[1] for every k
          a_nx     = ~idx_bit1;
          state_nx = S_DRIVE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
